// File: rtl/md5_core_scheduler_if.sv
// Handshake and core-array bundle for md5_core_scheduler.
// master drives candidates and core status, slave is the scheduler.
interface md5_core_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int POS_W     = 16
);
  logic                       start;
  logic [127:0]               target_hash;
  logic                       cand_valid;
  logic                       cand_ready;
  logic [POS_W-1:0]           cand_pos;
  logic                       cand_last;
  logic [NUM_CORES-1:0]       core_start;
  logic [NUM_CORES-1:0]       core_busy;
  logic [NUM_CORES-1:0]       core_done;
  logic [NUM_CORES*128-1:0]   core_digest;
  logic                       block_done;
  logic                       match;
  logic [POS_W-1:0]           match_pos;
  logic                       proto_err;

  modport master (
    output start, target_hash,
    output cand_valid, cand_pos, cand_last,
    output core_busy, core_done, core_digest,
    input  cand_ready, core_start,
    input  block_done, match, match_pos, proto_err
  );

  modport slave (
    input  start, target_hash,
    input  cand_valid, cand_pos, cand_last,
    input  core_busy, core_done, core_digest,
    output cand_ready, core_start,
    output block_done, match, match_pos, proto_err
  );
endinterface

// File: rtl/md5_core_scheduler.sv
// Round-robin dispatcher of candidate windows onto md5 cores,
// tracking in-flight tags and reporting the earliest matching position.
module md5_core_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int POS_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  md5_core_scheduler_if.slave   bus
);

  localparam int RR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = $clog2(NUM_CORES) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [RR_W-1:0]      r_rr;
  logic [NUM_CORES-1:0] r_inflight;
  logic [POS_W-1:0]     r_tag [NUM_CORES];
  logic [CNT_W-1:0]     r_outstanding;
  logic                 r_match;
  logic [POS_W-1:0]     r_match_pos;
  logic                 r_proto_err;

  logic [NUM_CORES-1:0] w_idle;
  logic                 w_ready;
  logic                 w_accept;
  logic [NUM_CORES-1:0] w_start_vec;
  logic [NUM_CORES-1:0] w_cmpl;
  logic [NUM_CORES-1:0] w_spur;
  logic [RR_W-1:0]      w_rr_next;
  logic [CNT_W-1:0]     w_ncmpl;
  logic [CNT_W-1:0]     w_out_next;
  logic                 w_best_vld;
  logic [POS_W-1:0]     w_best_tag;
  logic                 w_take;

  assign w_idle   = ~bus.core_busy & ~r_inflight;
  assign w_ready  = (r_state == S_RUN) && !r_match
                    && w_idle[r_rr];
  assign w_accept = bus.cand_valid & w_ready;

  assign w_start_vec = w_accept
                       ? (NUM_CORES'(1) << r_rr)
                       : '0;

  assign w_cmpl = bus.core_done & r_inflight;
  assign w_spur = bus.core_done & ~r_inflight;

  assign w_rr_next = (r_rr == RR_W'(NUM_CORES - 1))
                     ? '0
                     : r_rr + RR_W'(1);

  always_comb begin
    w_ncmpl = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_ncmpl = w_ncmpl + CNT_W'(w_cmpl[k]);
    end
  end

  // a dispatch and a completion in the same cycle cancel out
  assign w_out_next = r_outstanding
                      + CNT_W'(w_accept)
                      - w_ncmpl;

  // lowest tag among this cycle's matching completions
  always_comb begin
    w_best_vld = 1'b0;
    w_best_tag = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (w_cmpl[k] &&
          bus.core_digest[k*128 +: 128] == bus.target_hash) begin
        if (!w_best_vld || r_tag[k] < w_best_tag) begin
          w_best_vld = 1'b1;
          w_best_tag = r_tag[k];
        end
      end
    end
  end

  assign w_take = w_best_vld
                  && (!r_match || w_best_tag < r_match_pos);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_rr          <= '0;
      r_inflight    <= '0;
      r_outstanding <= '0;
      r_match       <= 1'b0;
      r_match_pos   <= '0;
      r_proto_err   <= 1'b0;
      for (int k = 0; k < NUM_CORES; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      r_proto_err   <= r_proto_err | (|w_spur);
      r_inflight    <= (r_inflight & ~w_cmpl) | w_start_vec;
      r_outstanding <= w_out_next;

      if (w_accept) begin
        r_tag[r_rr] <= bus.cand_pos;
        r_rr        <= w_rr_next;
      end

      if (w_take) begin
        r_match     <= 1'b1;
        r_match_pos <= w_best_tag;
      end

      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state     <= S_RUN;
            r_match     <= 1'b0;
            r_match_pos <= '0;
            r_rr        <= '0;
          end
        end
        S_RUN: begin
          if ((w_accept && bus.cand_last) || w_best_vld) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_out_next == '0) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cand_ready = w_ready;
  assign bus.core_start = w_start_vec;
  assign bus.block_done = (r_state == S_DONE);
  assign bus.match      = r_match;
  assign bus.match_pos  = r_match_pos;
  assign bus.proto_err  = r_proto_err;

endmodule

// File: tb/tb_md5_core_scheduler.sv
// Scoreboard bench for md5_core_scheduler with a latency model of the
// md5 core array; expected dispatch order and results are queued.
module tb_md5_core_scheduler;
  localparam int NC = 4;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  md5_core_scheduler_if #(.NUM_CORES(NC), .POS_W(PW)) bus();

  md5_core_scheduler #(.NUM_CORES(NC), .POS_W(PW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  int            cnt [NC];
  int            lat [NC];
  logic [PW-1:0] mtag [NC];
  bit            hit_mask [256];
  logic [127:0]  tgt = '0;
  logic [NC-1:0] man_done = '0;
  logic [NC-1:0] m_done;
  logic [NC-1:0] m_busy;
  int            cyc = 0;
  int            last_done_cyc = 0;
  int            sess = 0;
  bit            prev_bd = 1'b0;

  logic [NC-1:0] exp_start_q [$];
  logic [PW:0]   exp_done_q [$];

  localparam logic [127:0] T2_HASH =
    128'h0a4db18ed352b277c1292e9ef323d450;

  task automatic chk(string name, logic [127:0] act,
                     logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tmo(string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout", name);
  endtask

  // md5 core array model
  always begin
    @(negedge clk);
    cyc++;
    for (int k = 0; k < NC; k++) begin
      m_done[k] = 1'b0;
      m_busy[k] = 1'b0;
      if (cnt[k] > 0) begin
        cnt[k]--;
        if (cnt[k] == 0) m_done[k] = 1'b1;
        else m_busy[k] = 1'b1;
      end
      bus.core_digest[k*128 +: 128] =
        hit_mask[mtag[k][7:0]] ? tgt : (~tgt ^ 128'(mtag[k]));
    end
    bus.core_busy = m_busy;
    bus.core_done = m_done | man_done;
    #2;
    for (int k = 0; k < NC; k++) begin
      if (bus.core_start[k]) begin
        cnt[k]  = lat[k];
        mtag[k] = bus.cand_pos;
      end
    end
  end

  // monitor: pops expected values when the DUT presents output
  always begin
    @(negedge clk);
    #3;
    if (bus.core_start != '0) begin
      if (exp_start_q.size() == 0)
        chk("unexpected core_start", bus.core_start, '0);
      else
        chk("core_start order", bus.core_start,
            exp_start_q.pop_front());
    end
    if (bus.block_done && !prev_bd) begin
      if (exp_done_q.size() == 0) begin
        tmo("unexpected block_done");
      end else begin
        logic [PW:0] e;
        e = exp_done_q.pop_front();
        chk("match", bus.match, e[PW]);
        chk("match_pos", bus.match_pos, e[PW-1:0]);
        chk("done latency", cyc - last_done_cyc, 1);
      end
    end
    if (bus.core_done != '0) last_done_cyc = cyc;
    prev_bd = bus.block_done;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(logic [127:0] t, bit fresh);
    tgt = t;
    bus.target_hash = t;
    bus.start = 1'b1;
    if (fresh) sess = 0;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(int pos, bit last, output bit ok);
    bit stop;
    bus.cand_valid = 1'b1;
    bus.cand_pos   = PW'(pos);
    bus.cand_last  = last;
    exp_start_q.push_back(NC'(1) << (sess % NC));
    ok = 1'b0;
    stop = 1'b0;
    for (int w = 0; w < 2000; w++) begin
      #1;
      if (bus.cand_ready) begin
        ok = 1'b1;
        break;
      end
      if (bus.match || bus.block_done) begin
        stop = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      sess++;
      tick();
    end else begin
      void'(exp_start_q.pop_back());
      if (!stop) tmo("cand accept");
    end
    bus.cand_valid = 1'b0;
    bus.cand_last  = 1'b0;
  endtask

  task automatic wait_done();
    for (int w = 0; w < 5000; w++) begin
      if (bus.block_done) begin
        tick();
        return;
      end
      tick();
    end
    tmo("block_done");
  endtask

  task automatic set_lat(int l0, int l1, int l2, int l3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
  endtask

  task automatic clear_mask();
    for (int i = 0; i < 256; i++) hit_mask[i] = 1'b0;
  endtask

  task automatic check_idle_outs(string tag);
    chk({tag, " cand_ready"}, bus.cand_ready, 0);
    chk({tag, " core_start"}, bus.core_start, 0);
    chk({tag, " block_done"}, bus.block_done, 0);
    chk({tag, " match"}, bus.match, 0);
    chk({tag, " match_pos"}, bus.match_pos, 0);
    chk({tag, " proto_err"}, bus.proto_err, 0);
  endtask

  initial begin
    bit ok;
    int bad;
    bus.start       = 1'b0;
    bus.target_hash = '0;
    bus.cand_valid  = 1'b0;
    bus.cand_pos    = '0;
    bus.cand_last   = 1'b0;
    bus.core_busy   = '0;
    bus.core_done   = '0;
    bus.core_digest = '0;
    for (int k = 0; k < NC; k++) begin
      cnt[k] = 0;
      mtag[k] = '0;
    end
    set_lat(64, 64, 64, 64);
    clear_mask();
    repeat (3) tick();
    bus.cand_valid = 1'b1;
    #1;
    check_idle_outs("reset");
    bus.cand_valid = 1'b0;
    reset_n = 1'b1;
    tick();

    // no-match block of 8 candidates
    do_start(128'h0123456789abcdef0011223344556677, 1'b1);
    exp_done_q.push_back({1'b0, PW'(0)});
    for (int i = 0; i < 8; i++) send(i, i == 7, ok);
    wait_done();

    // single match at position 122 of 200
    clear_mask();
    hit_mask[122] = 1'b1;
    do_start(T2_HASH, 1'b1);
    exp_done_q.push_back({1'b1, PW'(122)});
    for (int i = 0; i < 200; i++) begin
      send(i, i == 199, ok);
      if (!ok) break;
    end
    chk("ready after match", bus.cand_ready, 0);
    wait_done();

    // out-of-order completion, tags 41 (core1) and 40 (core2)
    clear_mask();
    hit_mask[40] = 1'b1;
    hit_mask[41] = 1'b1;
    set_lat(64, 66, 64, 64);
    do_start(128'hfeedface_00000000_cafebabe_12345678, 1'b1);
    exp_done_q.push_back({1'b1, PW'(40)});
    send(99, 1'b0, ok);
    send(41, 1'b0, ok);
    send(40, 1'b0, ok);
    send(98, 1'b1, ok);
    wait_done();

    // round-robin stall on a long-busy core 1
    clear_mask();
    set_lat(8, 100, 8, 8);
    do_start(128'h5555aaaa5555aaaa5555aaaa5555aaaa, 1'b1);
    exp_done_q.push_back({1'b0, PW'(0)});
    for (int i = 0; i < 5; i++) send(i, 1'b0, ok);
    bad = 0;
    fork
      send(5, 1'b1, ok);
      begin
        repeat (60) begin
          #1;
          if (bus.cand_ready || bus.core_start != '0) bad++;
          tick();
        end
      end
    join
    chk("rr stall", bad, 0);
    wait_done();

    // completion on core 0 while a candidate waits for it
    set_lat(20, 40, 40, 40);
    do_start(128'h00000000ffffffff00000000ffffffff, 1'b1);
    exp_done_q.push_back({1'b0, PW'(0)});
    for (int i = 0; i < 4; i++) send(i, 1'b0, ok);
    fork
      send(4, 1'b1, ok);
      begin
        bit found;
        found = 1'b0;
        for (int w = 0; w < 100; w++) begin
          #1;
          if (bus.core_done[0]) begin
            found = 1'b1;
            break;
          end
          tick();
        end
        if (found) begin
          chk("no dispatch on done", bus.core_start, 0);
          tick();
          #1;
          chk("dispatch next", bus.core_start, 4'b0001);
          tick();
          #1;
          chk("outstanding", dut.r_outstanding, 4);
        end else begin
          tmo("core_done[0]");
        end
      end
    join
    wait_done();

    // reset mid-session, spurious done, start ignored in RUN
    set_lat(200, 200, 200, 200);
    do_start(128'h13579bdf02468ace13579bdf02468ace, 1'b1);
    for (int i = 0; i < 3; i++) send(i, 1'b0, ok);
    tick();
    reset_n = 1'b0;
    for (int k = 0; k < NC; k++) cnt[k] = 0;
    bus.cand_valid = 1'b1;
    tick();
    #1;
    check_idle_outs("mid reset");
    bus.cand_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    man_done = 4'b0100;
    tick();
    man_done = '0;
    tick();
    chk("proto_err spurious", bus.proto_err, 1);
    set_lat(10, 10, 10, 10);
    do_start(128'habcdef0123456789abcdef0123456789, 1'b1);
    exp_done_q.push_back({1'b0, PW'(0)});
    send(0, 1'b0, ok);
    do_start(128'habcdef0123456789abcdef0123456789, 1'b0);
    send(1, 1'b1, ok);
    wait_done();
    chk("proto_err sticky", bus.proto_err, 1);

    repeat (3) tick();
    chk("start queue empty", exp_start_q.size(), 0);
    chk("done queue empty", exp_done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
